// File: rtl/k054539_sdo_rx_if.sv
// ---------------------------------------------------------------------------
// k054539_sdo_rx_if
// Stereo sample stream from the 054539 serial-output receiver to its consumer
// (mixer / DAC model).
//   OUT_L     [WIDTH]  left sample, two's complement
//   OUT_R     [WIDTH]  right sample, two's complement
//   OUT_VALID          OUT_L/OUT_R hold a pair
//   OUT_READY          consumer takes the pair when OUT_VALID & OUT_READY
// master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface k054539_sdo_rx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] OUT_L;
  logic [WIDTH-1:0] OUT_R;
  logic             OUT_VALID;
  logic             OUT_READY;

  modport master (output OUT_L, output OUT_R, output OUT_VALID, input OUT_READY);
  modport slave  (input OUT_L, input OUT_R, input OUT_VALID, output OUT_READY);
endinterface

// File: rtl/k054539_sdo_rx.sv
// ---------------------------------------------------------------------------
// k054539_sdo_rx
// Receives the 054539 serial DAC stream (DTCK bit clock, WDCK word clock,
// SDAT MSB-first data), oversampled by CLK. Deserialises words into signed
// left/right pairs, buffers them in a DEPTH-pair FIFO and presents them over
// a valid/ready stream. Flags short words and FIFO overflow (sticky).
//
// Parameters
//   WIDTH  sample width; the last WIDTH bits before a WDCK edge form the word
//   DEPTH  FIFO depth in pairs (power of two, >= 2)
//
// Ports
//   CLK        system clock, >= 4x DTCK
//   RES        asynchronous active-high reset
//   PIN_DTCK   bit clock, data taken on its rising edge
//   PIN_WDCK   word clock: fall ends left word, rise ends right word
//   PIN_SDAT   serial data, MSB first
//   out_if     stream to consumer (OUT_L, OUT_R, OUT_VALID, OUT_READY)
//   ERR_SHORT  sticky: a word had fewer than WIDTH bits
//   ERR_OVF    sticky: a pair was dropped because the FIFO was full
//   ERR_CLR    synchronous clear of both sticky flags (a same-cycle set wins)
//   OVF_CNT    [7:0] saturating dropped-pair count, present only when
//              K054539_SDO_RX_OVF_CNT_EN is defined
// ---------------------------------------------------------------------------
module k054539_sdo_rx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RES,
  input  logic                    PIN_DTCK,
  input  logic                    PIN_WDCK,
  input  logic                    PIN_SDAT,
  k054539_sdo_rx_if.master        out_if,
  output logic                    ERR_SHORT,
  output logic                    ERR_OVF,
`ifdef K054539_SDO_RX_OVF_CNT_EN
  output logic [7:0]              OVF_CNT,
`endif
  input  logic                    ERR_CLR
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
  } pair_t;

  typedef enum logic [1:0] {WAIT_L, WAIT_R, PUSH} state_t;

  // -------------------------------------------------------------------------
  // Input stage: [0],[1] synchroniser, [2] previous value for edge detect.
  // Reset to pin idle levels so release does not fake an edge.
  // -------------------------------------------------------------------------
  logic [2:0] dtck_q, wdck_q;
  logic [1:0] sdat_q;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      dtck_q <= 3'b000;
      wdck_q <= 3'b111;
      sdat_q <= 2'b00;
    end else begin
      dtck_q <= {dtck_q[1:0], PIN_DTCK};
      wdck_q <= {wdck_q[1:0], PIN_WDCK};
      sdat_q <= {sdat_q[0], PIN_SDAT};
    end
  end

  logic dtck_rise, wdck_fall, wdck_rise, sdat_sync;
  assign dtck_rise = dtck_q[1] & ~dtck_q[2];
  assign wdck_fall = ~wdck_q[1] & wdck_q[2];
  assign wdck_rise = wdck_q[1] & ~wdck_q[2];
  assign sdat_sync = sdat_q[1];

  // -------------------------------------------------------------------------
  // Shift register and bit counter. A bit arriving in the same cycle as a
  // word edge is shifted first, so the latched word includes it.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d, bitcnt_inc;
  logic             word_end, short_w;

  always_comb begin
    shreg_d    = dtck_rise ? {shreg_q[WIDTH-2:0], sdat_sync} : shreg_q;
    bitcnt_inc = (dtck_rise && bitcnt_q != CW'(WIDTH)) ? bitcnt_q + CW'(1) : bitcnt_q;
    word_end   = wdck_fall | wdck_rise;
    short_w    = bitcnt_inc < CW'(WIDTH);
    // The same-cycle bit also opens the count of the next word.
    bitcnt_d   = word_end ? (dtck_rise ? CW'(1) : '0) : bitcnt_inc;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Pair assembly FSM. bad_q marks a pair containing a short word; such a
  // pair is discarded at PUSH. A new left word replaces the mark, since the
  // old left word is replaced too.
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] l_q, l_d, r_q, r_d;
  logic             bad_q, bad_d;
  logic             push_req, short_evt;

  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    r_d       = r_q;
    bad_d     = bad_q;
    push_req  = 1'b0;
    short_evt = 1'b0;
    case (state_q)
      WAIT_L: begin
        // A right-word edge here belongs to a frame we joined midway.
        if (wdck_fall) begin
          l_d       = shreg_d;
          bad_d     = short_w;
          short_evt = short_w;
          state_d   = WAIT_R;
        end
      end
      WAIT_R: begin
        if (wdck_fall) begin
          l_d       = shreg_d;
          bad_d     = short_w;
          short_evt = short_w;
        end else if (wdck_rise) begin
          r_d       = shreg_d;
          bad_d     = bad_q | short_w;
          short_evt = short_w;
          state_d   = PUSH;
        end
      end
      PUSH: begin
        push_req = ~bad_q;
        bad_d    = 1'b0;
        state_d  = WAIT_L;
        if (wdck_fall) begin
          l_d       = shreg_d;
          bad_d     = short_w;
          short_evt = short_w;
          state_d   = WAIT_R;
        end
      end
      default: state_d = WAIT_L;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= WAIT_L;
      l_q     <= '0;
      r_q     <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      bad_q   <= bad_d;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO. The output registers mirror the head entry (they are not an extra
  // slot), so capacity is exactly DEPTH pairs. They are loaded from the
  // post-pop FIFO state, giving one register stage after the write.
  // -------------------------------------------------------------------------
  pair_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]     wptr_q, rptr_q, rptr_d;
  logic [NW-1:0]     cnt_q, cnt_d, cnt_pop;
  logic              full, pop, push_ok, drop;
  logic [WIDTH-1:0]  out_l_q, out_r_q;
  logic              out_valid_q, out_valid_d;
  pair_t             head;

  always_comb begin
    full        = cnt_q == NW'(DEPTH);
    pop         = out_valid_q & out_if.OUT_READY;
    push_ok     = push_req & (~full | pop);
    drop        = push_req & full & ~pop;
    cnt_d       = cnt_q + NW'(push_ok) - NW'(pop);
    cnt_pop     = cnt_q - NW'(pop);
    rptr_d      = rptr_q + PW'(pop);
    out_valid_d = cnt_pop != '0;
    head        = mem_q[rptr_d];
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      mem_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= '{l: l_q, r: r_q};
        wptr_q        <= wptr_q + PW'(1);
      end
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= head.l;
      out_r_q     <= head.r;
    end
  end

  assign out_if.OUT_L     = out_l_q;
  assign out_if.OUT_R     = out_r_q;
  assign out_if.OUT_VALID = out_valid_q;

  // -------------------------------------------------------------------------
  // Sticky error flags; a set event in the clear cycle wins.
  // -------------------------------------------------------------------------
  logic err_short_q, err_ovf_q;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      err_short_q <= short_evt | (err_short_q & ~ERR_CLR);
      err_ovf_q   <= drop | (err_ovf_q & ~ERR_CLR);
    end
  end

  assign ERR_SHORT = err_short_q;
  assign ERR_OVF   = err_ovf_q;

`ifdef K054539_SDO_RX_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    if (ERR_CLR)                      ovf_cnt_d = {7'd0, drop};
    else if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    else                              ovf_cnt_d = ovf_cnt_q;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) ovf_cnt_q <= 8'd0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign OVF_CNT = ovf_cnt_q;
`endif

endmodule

// File: doc/k054539_sdo_rx.md
Name: k054539_sdo_rx

Overview:
- Downstream consumer of the 054539 serial DAC output: DTCK bit clock, WDCK word/channel clock, serial data.
- Samples the three pins with the system clock and deserialises MSB-first words into signed left/right sample pairs.
- Buffers pairs in a small FIFO with a valid/ready handshake toward the mixer/DAC model.
- Catches malformed frames and overflow for the bench and emulation core.

Parameters:
WIDTH, 16, sample width in bits; the last WIDTH bits before a WDCK edge form the word.
DEPTH, 4, FIFO depth in stereo pairs (power of two, >= 2).

Ports:
CLK  in  1  system clock; at least 4x DTCK rate.
RES  in  1  asynchronous active-high reset.
PIN_DTCK  in  1  serial bit clock from 054539; data sampled on its rising edge.
PIN_WDCK  in  1  word clock; falling edge ends left word, rising edge ends right word.
PIN_SDAT  in  1  serial data, MSB first.
OUT_L  out  WIDTH  left sample, two's complement.
OUT_R  out  WIDTH  right sample, two's complement.
OUT_VALID  out  1  OUT_L/OUT_R hold a pair.
OUT_READY  in  1  consumer accepts the pair when OUT_VALID & OUT_READY.
ERR_SHORT  out  1  sticky: a word had fewer than WIDTH bits.
ERR_OVF  out  1  sticky: a pair was dropped because the FIFO was full.
ERR_CLR  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset:
  - Clock and reset: one clock, CLK; reset RES is asynchronous and active-high.
  - All outputs are 0 during and after reset; FIFO is empty, shift register and bit counter are 0.
  - Sync flops take the pin idle values: DTCK=0, WDCK=1, SDAT=0.
  - An edge on the first cycle after reset release is not detected.
- Input stage: each pin passes through a 2-FF synchroniser. A third register gives edge detection: dtck_rise, wdck_fall, wdck_rise.
- Shift (dtck_rise):
  - shreg <= {shreg[WIDTH-2:0], sdat_sync}.
  - bitcnt increments and saturates at WIDTH.
- Word end (WDCK edge):
  - Same-cycle dtck_rise and WDCK edge: the bit is shifted first, and the word includes it.
  - The word is then latched to the left holding register (fall) or right holding register (rise).
  - bitcnt resets to 0, or to 1 if a bit was shifted in that same cycle.
  - The word is short if bitcnt < WIDTH at the edge. A short word sets ERR_SHORT and marks the pair bad.
  - More than WIDTH bits: only the last WIDTH are kept; this is not an error.
- Pair assembly:
  - State machine WAIT_L -> WAIT_R -> PUSH -> WAIT_L.
  - WAIT_L leaves only on wdck_fall. In WAIT_R, a wdck_rise goes to PUSH; a second wdck_fall re-latches left and stays in WAIT_R.
  - PUSH lasts one cycle. It writes {L,R} to the FIFO unless the pair is bad, then clears the bad mark.
  - A wdck_rise seen in WAIT_L (e.g. the first frame after reset) is ignored.
- FIFO (DEPTH entries):
  - Push to a full FIFO drops the new pair and sets ERR_OVF; stored pairs are never overwritten.
  - Simultaneous push and pop when full: the pop frees a slot, the push succeeds, and no overflow is flagged.
  - Pop occurs on OUT_VALID & OUT_READY.
  - OUT_L/OUT_R/OUT_VALID are registered from the FIFO head and are stable while OUT_VALID=1 and OUT_READY=0.
  - Pointers wrap modulo DEPTH; a count register distinguishes full from empty.
- Latency: a pin WDCK rising edge that completes a good pair, with the FIFO empty, gives OUT_VALID=1 on the 5th CLK rising edge (2 sync + 1 edge + 1 PUSH + 1 output register).
- ERR_CLR:
  - Clears both flags next cycle.
  - If an error event occurs in the same cycle as ERR_CLR, the set wins.

Optional Feature:
- Macro: K054539_SDO_RX_OVF_CNT_EN.
- Defined: adds output OVF_CNT [7:0]. It counts dropped pairs, saturates at 255, and is cleared by RES and ERR_CLR; a same-cycle drop with ERR_CLR yields 1.
- Undefined: the port and counter are absent; ERR_OVF behaviour is unchanged.

Test Plan:
- Reset, then send frames with L=16'h1234 and R=16'hEDCB (16 bits each, DTCK = CLK/8), OUT_READY=1.
  - OUT_L=1234, OUT_R=EDCB.
  - OUT_VALID pulses once, 5 CLK after the pin WDCK rise.
- Hold OUT_READY=0 and send 5 pairs (0001/0002 ... 0005/0006).
  - FIFO holds pairs 1-4; ERR_OVF=1 after pair 5.
  - Releasing OUT_READY yields exactly pairs 1-4 in order.
  - With OVF_CNT_EN, OVF_CNT=1.
- Send an 18-bit left word 2'b11 then 16'h8000, followed by a normal right word.
  - OUT_L=8000 and ERR_SHORT stays 0.
- Send a 12-bit left word, then a good right word.
  - No pair is output; ERR_SHORT=1.
  - Pulse ERR_CLR: ERR_SHORT=0 next cycle.
- Place a DTCK rise and a WDCK rise at the same synchronised cycle carrying the LSB=1 of R=16'h0001.
  - OUT_R=0001.
- Assert RES mid-word after 7 bits.
  - All outputs go to 0 immediately.
  - After release, the first complete pair decodes correctly and the partial word is never output.
